// File: rtl/key_conditioner.sv
// Free-play input front end: 2-FF sync, debounce and press pulses for buttons and switch buses.
// Optional feature: define HOLD_REPEAT_EN to auto-repeat en_hit while the hit button is held.

module key_conditioner_chan #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  input  logic [W-1:0] st_i,
  output logic [W-1:0] st_d_o
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic [W-1:0]  s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    st_d_o = st_i;
    cnt_d  = cnt_q;
    if (s2_q == st_i) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      st_d_o = s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

module key_conditioner #(
  parameter int DEB_CYCLES    = 2000000,
  parameter int NOTE_W        = 7,
  parameter int LENGTH_W      = 3,
  parameter int REPEAT_CYCLES = 30000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                raw_hit,
  input  logic                raw_up,
  input  logic                raw_down,
  input  logic [NOTE_W-1:0]   raw_note,
  input  logic [LENGTH_W-1:0] raw_length,
  output logic                en_hit,
  output logic                oct_up,
  output logic                oct_down,
  output logic [NOTE_W-1:0]   note_key,
  output logic [LENGTH_W-1:0] length_key
);
  logic                hit_st_q, up_st_q, down_st_q;
  logic                hit_st_d, up_st_d, down_st_d;
  logic [NOTE_W-1:0]   note_st_q, note_st_d;
  logic [LENGTH_W-1:0] length_st_q, length_st_d;
  logic                en_hit_q, oct_up_q, oct_down_q;
  logic                hit_rise, up_rise, down_rise, rep_fire;

  key_conditioner_chan #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_hit (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_hit), .st_i(hit_st_q), .st_d_o(hit_st_d));
  key_conditioner_chan #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_up), .st_i(up_st_q), .st_d_o(up_st_d));
  key_conditioner_chan #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_down (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_down), .st_i(down_st_q), .st_d_o(down_st_d));
  key_conditioner_chan #(.W(NOTE_W), .DEB_CYCLES(DEB_CYCLES)) u_note (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_note), .st_i(note_st_q), .st_d_o(note_st_d));
  key_conditioner_chan #(.W(LENGTH_W), .DEB_CYCLES(DEB_CYCLES)) u_length (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_length), .st_i(length_st_q), .st_d_o(length_st_d));

  // Rises are taken from the next-state value so the pulse lands on the flip edge itself.
  assign hit_rise  = ~hit_st_q & hit_st_d;
  assign up_rise   = ~up_st_q & up_st_d;
  assign down_rise = ~down_st_q & down_st_d;

`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rep_q, rep_d;

  always_comb begin
    rep_fire = 1'b0;
    rep_d    = '0;
    if (hit_st_q && en) begin
      if (rep_q == RW'(REPEAT_CYCLES - 1)) rep_fire = 1'b1;
      else                                 rep_d    = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  // Repeat disabled: constant-false, still referencing the period parameter.
  assign rep_fire = (REPEAT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_st_q    <= 1'b0;
      up_st_q     <= 1'b0;
      down_st_q   <= 1'b0;
      note_st_q   <= '0;
      length_st_q <= '0;
      en_hit_q    <= 1'b0;
      oct_up_q    <= 1'b0;
      oct_down_q  <= 1'b0;
    end else begin
      hit_st_q    <= hit_st_d;
      up_st_q     <= up_st_d;
      down_st_q   <= down_st_d;
      note_st_q   <= note_st_d;
      length_st_q <= length_st_d;
      en_hit_q    <= en & (hit_rise | rep_fire);
      oct_up_q    <= en & up_rise & ~down_rise;
      oct_down_q  <= en & down_rise & ~up_rise;
    end
  end

  assign en_hit     = en_hit_q;
  assign oct_up     = oct_up_q;
  assign oct_down   = oct_down_q;
  assign note_key   = note_st_q;
  assign length_key = length_st_q;
endmodule
